// File: rtl/int_arb_pkg.sv
// Shared types, register map and priority-pick helper for the INT2 source arbiter.
package int_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLAIM,
    ST_ACK,
    ST_WAIT_END
  } arb_state_t;

  localparam logic [1:0] REG_VBASE   = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_PENDING = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam logic [7:0] SPURIOUS_VEC_DFLT = 8'h0F;

  // First set bit of mask at or above ptr, wrapping modulo n; ptr=0 gives fixed priority.
  function automatic logic [2:0] rr_pick(input logic [7:0] mask,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0] sel;
    logic       found;
    logic [3:0] idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < 8; off++) begin
      idx = {1'b0, ptr} + 4'(off);
      if (idx >= 4'(n)) idx = idx - 4'(n);
      if (off < n && !found && mask[idx[2:0]]) begin
        sel   = idx[2:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/int_sync_bank.sv
// Multi-stage synchroniser bank for asynchronous active-low request levels.
module int_sync_bank #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Resets to all-ones: the inputs are active-low, so this is the idle level.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < STAGES; i++) stage[i] <= '1;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/int_source_arbiter.sv
// INT2 interrupt controller: masks and prioritises sources, runs the IACK claim/ack handshake.
module int_source_arbiter
  import int_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter bit          RR_EN        = 1'b1,
  parameter logic [7:0]  SPURIOUS_VEC = SPURIOUS_VEC_DFLT
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] src_req_n,
  input  logic               reg_wr,
  input  logic [1:0]         reg_addr,
  input  logic [7:0]         reg_wdata,
  output logic [7:0]         reg_rdata,
  input  logic               iack_start,
  input  logic               iack_ds,
  input  logic               cycle_end,
  output logic               int_req,
  output logic               iack_slave,
  output logic               iack_dtack,
  output logic [7:0]         vec_out
);

  arb_state_t state, next_state;

  logic [NUM_SRC-1:0] sync_n;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] pend_en;
  logic [NUM_SRC-1:0] clr_mask;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [7:0]         vbase;
  logic               assigned;
  logic               spurious;
  logic [2:0]         winner;
  logic [2:0]         rr_ptr;
  logic [2:0]         pick;
  logic [7:0]         pend_ext;
  logic [7:0]         en_ext;
  logic [7:0]         vec_next;
  logic               start_claim;
  logic               complete;

  int_sync_bank #(
    .WIDTH (NUM_SRC),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK  (CLK),
    .RESET(RESET),
    .d    (src_req_n),
    .q    (sync_n)
  );

  assign req     = ~sync_n;
  assign pend_en = pending & enable;

  always_comb begin
    pend_ext                = '0;
    en_ext                  = '0;
    pend_ext[NUM_SRC-1:0]   = pend_en;
    en_ext[NUM_SRC-1:0]     = enable;
  end

  assign pick     = rr_pick(pend_ext, RR_EN ? rr_ptr : 3'd0, NUM_SRC);
  assign vec_next = spurious ? SPURIOUS_VEC : {vbase[7:3], winner};

  always_comb begin
    next_state  = state;
    start_claim = 1'b0;
    complete    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (iack_start && int_req) begin
          next_state  = ST_CLAIM;
          start_claim = 1'b1;
        end
      end
      ST_CLAIM: begin
        if (iack_ds)        next_state = ST_ACK;
        else if (cycle_end) next_state = ST_IDLE;
      end
      ST_ACK: begin
        if (cycle_end) begin
          next_state = ST_WAIT_END;
          complete   = 1'b1;
        end
      end
      ST_WAIT_END: next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    clr_mask = '0;
    w1c_mask = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      clr_mask[i] = complete && !spurious && (winner == 3'(i));
    end
    if (reg_wr && reg_addr == REG_PENDING) w1c_mask = reg_wdata[NUM_SRC-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake outputs are registered off next_state so each asserts one cycle after its cause.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending    <= '0;
      enable     <= '0;
      vbase      <= '0;
      assigned   <= 1'b0;
      spurious   <= 1'b0;
      winner     <= '0;
      rr_ptr     <= '0;
      int_req    <= 1'b0;
      iack_slave <= 1'b0;
      iack_dtack <= 1'b0;
      vec_out    <= '0;
    end else begin
      pending <= (pending & ~clr_mask & ~w1c_mask) | (req & enable);
      if (reg_wr && reg_addr == REG_VBASE) begin
        vbase    <= reg_wdata;
        assigned <= 1'b1;
      end
      if (reg_wr && reg_addr == REG_ENABLE) enable <= reg_wdata[NUM_SRC-1:0];
      if (start_claim) begin
        winner   <= pick;
        spurious <= (pend_en == '0);
      end
      if (complete && !spurious) begin
        rr_ptr <= (winner == 3'(NUM_SRC - 1)) ? 3'd0 : winner + 3'd1;
      end
      int_req    <= (|pend_en) && assigned && (next_state == ST_IDLE);
      iack_slave <= (next_state == ST_CLAIM);
      iack_dtack <= (next_state == ST_ACK);
      vec_out    <= (next_state == ST_ACK) ? vec_next : '0;
    end
  end

  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr)
      REG_VBASE:   reg_rdata = vbase;
      REG_ENABLE:  reg_rdata = en_ext;
      REG_PENDING: reg_rdata = pend_ext;
      REG_STATUS:  reg_rdata = {1'b0, winner, 2'b00, (state != ST_IDLE), assigned};
      default:     reg_rdata = '0;
    endcase
  end

endmodule
